// File: rtl/buffer_pkg.sv
// Shared constants and width helpers for the multi-port circular buffer.
package buffer_pkg;

    localparam int DEF_BITS      = 12;
    localparam int DEF_DEPTH     = 60;
    localparam int DEF_PAR_WRITE = 2;
    localparam int DEF_PAR_READ  = 2;

    // Bits needed to encode values 0..n-1 (never less than one bit).
    function automatic int clog2w(input int n);
        int w;
        w = 0;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ring_ptr_adv.sv
// Modulo-DEPTH pointer advance; the step never exceeds DEPTH, so one
// conditional subtraction is enough to wrap.
module ring_ptr_adv #(
    parameter int DEPTH = 60,
    parameter int PW    = 6,
    parameter int SW    = 2
) (
    input  logic [PW-1:0] ptr_i,
    input  logic [SW-1:0] step_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW:0] DEPTH_X = (PW+1)'(DEPTH);

    logic [PW:0] sum_s;

    // Add the step one bit wider than the pointer, then fold back past DEPTH-1.
    always_comb begin
        sum_s = {1'b0, ptr_i} + (PW+1)'(step_i);
        if (sum_s >= DEPTH_X) begin
            ptr_o = PW'(sum_s - DEPTH_X);
        end else begin
            ptr_o = sum_s[PW-1:0];
        end
    end

endmodule

// File: rtl/multi_port_circular_buffer.sv
// Circular buffer accepting up to PAR_WRITE words and releasing up to
// PAR_READ words per cycle, first-word-fall-through on dout.
module multi_port_circular_buffer
    import buffer_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PAR_WRITE = DEF_PAR_WRITE,
    parameter int PAR_READ  = DEF_PAR_READ,
    parameter int AF_TH     = DEPTH - PAR_WRITE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              write_en,
    input  logic [clog2w(PAR_WRITE+1)-1:0]    write_num,
    input  logic [PAR_WRITE*BITS-1:0]         din,
    input  logic                              read_en,
    input  logic [clog2w(PAR_READ+1)-1:0]     read_num,
    output logic [PAR_READ*BITS-1:0]          dout,
    output logic                              valid,
    output logic                              ready,
    output logic [clog2w(DEPTH+1)-1:0]        count,
    output logic                              almost_full,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int WNW = clog2w(PAR_WRITE + 1);
    localparam int RNW = clog2w(PAR_READ + 1);
    localparam int CW  = clog2w(DEPTH + 1);
    localparam int PW  = clog2w(DEPTH);
    localparam int SW  = clog2w(imax(PAR_WRITE, PAR_READ) + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PARW_C  = CW'(PAR_WRITE);
    localparam logic [CW-1:0] PARR_C  = CW'(PAR_READ);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;

    logic [CW-1:0]   free_s, wadd_s, rsub_s;
    logic            wr_go_s, wr_rej_s, rd_go_s, rd_rej_s;
    logic [SW-1:0]   wstep_s, rstep_s;
    logic [PW-1:0]   head_adv_s, tail_adv_s;
    logic [PW-1:0]   widx_s [PAR_WRITE];
    logic [PW-1:0]   ridx_s [PAR_READ];
    logic [PAR_WRITE-1:0] we_lane_s;

    assign free_s = DEPTH_C - count_q;

    // Accept/reject decisions from start-of-cycle occupancy; flush overrides both.
    always_comb begin
        wr_go_s  = 1'b0;
        wr_rej_s = 1'b0;
        rd_go_s  = 1'b0;
        rd_rej_s = 1'b0;
        if (write_en && (write_num != {WNW{1'b0}})) begin
            if (CW'(write_num) <= free_s) begin
                wr_go_s = ~flush;
            end else begin
                wr_rej_s = 1'b1;
            end
        end else begin
            wr_go_s = 1'b0;
        end
        if (read_en && (read_num != {RNW{1'b0}})) begin
            if (CW'(read_num) <= count_q) begin
                rd_go_s = ~flush;
            end else begin
                rd_rej_s = 1'b1;
            end
        end else begin
            rd_go_s = 1'b0;
        end
        wstep_s = wr_go_s ? SW'(write_num) : {SW{1'b0}};
        rstep_s = rd_go_s ? SW'(read_num)  : {SW{1'b0}};
        wadd_s  = wr_go_s ? CW'(write_num) : {CW{1'b0}};
        rsub_s  = rd_go_s ? CW'(read_num)  : {CW{1'b0}};
    end

    ring_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .SW(SW)) u_tail_adv (
        .ptr_i (tail_q),
        .step_i(wstep_s),
        .ptr_o (tail_adv_s)
    );

    ring_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .SW(SW)) u_head_adv (
        .ptr_i (head_q),
        .step_i(rstep_s),
        .ptr_o (head_adv_s)
    );

    // Per-lane storage indices: tail+i for writes, head+i for the read window.
    for (genvar g = 0; g < PAR_WRITE; g++) begin : g_widx
        ring_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .SW(SW)) u_adv (
            .ptr_i (tail_q),
            .step_i(SW'(g)),
            .ptr_o (widx_s[g])
        );
    end

    for (genvar g = 0; g < PAR_READ; g++) begin : g_ridx
        ring_ptr_adv #(.DEPTH(DEPTH), .PW(PW), .SW(SW)) u_adv (
            .ptr_i (head_q),
            .step_i(SW'(g)),
            .ptr_o (ridx_s[g])
        );
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            head_d  = head_adv_s;
            tail_d  = tail_adv_s;
            count_d = count_q + wadd_s - rsub_s;
            ovf_d   = ovf_q | wr_rej_s;
            unf_d   = unf_q | rd_rej_s;
        end
    end

    // Enable only the lanes that carry real words this cycle.
    always_comb begin
        we_lane_s = {PAR_WRITE{1'b0}};
        for (int i = 0; i < PAR_WRITE; i++) begin
            we_lane_s[i] = wr_go_s && (WNW'(i) < write_num);
        end
    end

    // Storage is deliberately left unreset; only accepted lanes are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PAR_WRITE; i++) begin
            if (we_lane_s[i]) begin
                mem_q[widx_s[i]] <= din[i*BITS +: BITS];
            end
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // First-word-fall-through window starting at head.
    always_comb begin
        dout = {(PAR_READ*BITS){1'b0}};
        for (int i = 0; i < PAR_READ; i++) begin
            dout[i*BITS +: BITS] = mem_q[ridx_s[i]];
        end
    end

    assign count       = count_q;
    assign valid       = (count_q >= PARR_C);
    assign ready       = (free_s >= PARW_C);
    assign almost_full = (count_q >= AF_C);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_multi_port_circular_buffer.sv
// Scoreboard bench: each stimulus step pushes the expected post-edge view of
// the buffer (from a word-queue model); a negedge monitor pops and compares.
module tb_multi_port_circular_buffer;

    localparam int BITS  = 12;
    localparam int DEPTH = 60;
    localparam int PWR   = 2;
    localparam int PRD   = 2;
    localparam int AF    = DEPTH - PWR;

    logic        clk = 1'b0;
    logic        rst, flush, write_en, read_en;
    logic [1:0]  write_num, read_num;
    logic [23:0] din;
    logic [23:0] dout;
    logic        valid, ready, almost_full, overflow, underflow;
    logic [5:0]  count;

    multi_port_circular_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .write_en(write_en),
        .write_num(write_num), .din(din), .read_en(read_en),
        .read_num(read_num), .dout(dout), .valid(valid), .ready(ready),
        .count(count), .almost_full(almost_full), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt; bit v; bit r; bit af; bit ov; bit un; int w0; int w1;
    } exp_t;

    exp_t sbq[$];
    int   mq[$];
    bit   m_ov = 1'b0;
    bit   m_un = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // Drive one cycle of requests at posedge+1, update the model, push expectation.
    task automatic step(input bit fl, input bit we, input int wn, input int d0,
                        input int d1, input bit re, input int rn);
        int   c;
        exp_t e;
        flush     = fl;
        write_en  = we;
        write_num = 2'(wn);
        din       = {d1[11:0], d0[11:0]};
        read_en   = re;
        read_num  = 2'(rn);
        c = mq.size();
        if (fl) begin
            model_reset();
        end else begin
            if (we && wn > DEPTH - c) m_ov = 1'b1;
            if (re && rn > c) m_un = 1'b1;
            if (re && rn != 0 && rn <= c) repeat (rn) void'(mq.pop_front());
            if (we && wn != 0 && wn <= DEPTH - c) begin
                mq.push_back(d0 & 4095);
                if (wn > 1) mq.push_back(d1 & 4095);
            end
        end
        e.cnt = mq.size();
        e.v   = (e.cnt >= PRD);
        e.r   = (DEPTH - e.cnt >= PWR);
        e.af  = (e.cnt >= AF);
        e.ov  = m_ov;
        e.un  = m_un;
        e.w0  = (e.cnt > 0) ? mq[0] : -1;
        e.w1  = (e.cnt > 1) ? mq[1] : -1;
        @(posedge clk);
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    // Monitor: compare DUT outputs with the oldest pending expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin : mon
            exp_t e;
            e = sbq.pop_front();
            check("count", int'(count), e.cnt);
            check("valid", int'(valid), int'(e.v));
            check("ready", int'(ready), int'(e.r));
            check("almost_full", int'(almost_full), int'(e.af));
            check("overflow", int'(overflow), int'(e.ov));
            check("underflow", int'(underflow), int'(e.un));
            if (e.w0 >= 0) check("dout_lane0", int'(dout[11:0]), e.w0);
            if (e.w1 >= 0) check("dout_lane1", int'(dout[23:12]), e.w1);
        end
    end

    task automatic check_reset_view(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_af"}, int'(almost_full), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_unf"}, int'(underflow), 0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            int ph;
            ph = (i / 150) % 2;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < (ph != 0 ? 85 : 40),
                 $urandom_range(0, 2), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 99) < (ph != 0 ? 40 : 85),
                 $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0;
        write_num = 2'd0; read_num = 2'd0; din = 24'd0;
        #12;
        check_reset_view("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-word write straight after reset.
        step(1'b0, 1'b1, 2, 5, 6, 1'b0, 0);
        // Bring occupancy to 1, then read 2 alongside write 2 (read rejected).
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1);
        step(1'b0, 1'b1, 2, 7, 8, 1'b1, 2);
        // Build up to 10, then read 2 / write 1, then flush with traffic present.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2, 20 + i, 40 + i, 1'b0, 0);
        step(1'b0, 1'b1, 1, 99, 0, 1'b0, 0);
        step(1'b0, 1'b1, 1, 100, 0, 1'b1, 2);
        step(1'b1, 1'b1, 2, 1, 2, 1'b1, 2);
        idle();

        // Fill to 59, overflow on a 2-word write, then top up to exactly full.
        for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 2, 200 + 2 * i, 201 + 2 * i, 1'b0, 0);
        step(1'b0, 1'b1, 1, 300, 0, 1'b0, 0);
        step(1'b0, 1'b1, 2, 301, 302, 1'b0, 0);
        step(1'b0, 1'b1, 1, 303, 0, 1'b0, 0);
        // Drain to head index 59, refill two words at 0/1, then read across the wrap.
        for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b1, 2);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1);
        step(1'b0, 1'b1, 2, 400, 401, 1'b0, 0);
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 2);
        idle();

        rand_steps(3000);

        // Asynchronous reset between edges with a burst in progress.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2, 500 + i, 600 + i, 1'b0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_view("midreset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_view("heldreset");
        rst = 1'b0;
        write_en = 1'b0;
        rand_steps(200);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_port_circular_buffer.md
MULTI_PORT_CIRCULAR_BUFFER -- requirements
Module: multi_port_circular_buffer

Interface
REQ-001 SHALL have parameter BITS, default 12, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 60, storage capacity in words; any value >= max(PAR_WRITE, PAR_READ); power of two not required.
REQ-003 SHALL have parameter PAR_WRITE, default 2, maximum words written per cycle.
REQ-004 SHALL have parameter PAR_READ, default 2, maximum words read per cycle.
REQ-005 SHALL have parameter AF_TH, default DEPTH-PAR_WRITE, almost-full threshold in words.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1, synchronous empty request.
REQ-009 SHALL have port write_en, input, 1, write request.
REQ-010 SHALL have port write_num, input, clog2(PAR_WRITE+1), words to write this cycle (0..PAR_WRITE).
REQ-011 SHALL have port din, input, PAR_WRITE*BITS, lane 0 in LSBs; lane 0 is the oldest word.
REQ-012 SHALL have port read_en, input, 1, read request.
REQ-013 SHALL have port read_num, input, clog2(PAR_READ+1), words to pop this cycle (0..PAR_READ).
REQ-014 SHALL have port dout, output, PAR_READ*BITS, lane i = word at head+i (first-word-fall-through).
REQ-015 SHALL have port valid, output, 1, high when count >= PAR_READ.
REQ-016 SHALL have port ready, output, 1, high when DEPTH-count >= PAR_WRITE.
REQ-017 SHALL have port count, output, clog2(DEPTH+1), current occupancy.
REQ-018 SHALL have port almost_full, output, 1, high when count >= AF_TH.
REQ-019 SHALL have ports overflow and underflow, outputs, 1 each, sticky error flags.

Function
REQ-020 SHALL accept a write when write_en=1 and write_num <= DEPTH-count, evaluated on start-of-cycle count; lanes 0..write_num-1 are stored in order at tail.
REQ-021 SHALL accept a read when read_en=1 and read_num <= count, evaluated on start-of-cycle count; head advances by read_num.
REQ-022 SHALL, on a rejected write, store nothing, leave tail unchanged, and set overflow.
REQ-023 SHALL, on a rejected read, leave head unchanged, and set underflow.
REQ-024 SHALL, when a read and a write are both accepted in one cycle, perform both; count_next = count + write_num - read_num.
REQ-025 SHALL, when write_num=0 or read_num=0, treat the request as a no-op with no error.
REQ-026 SHALL wrap head and tail modulo DEPTH, including a multi-word access that straddles index DEPTH-1 -> 0.
REQ-027 SHALL drive dout combinationally from storage at head; lanes i >= count carry don't-care data.
REQ-028 SHALL derive valid, ready, and almost_full combinationally from registered count only, with no path from any input.
REQ-029 SHALL, when flush=1, set head=tail=count=0 next edge, ignoring same-cycle read/write, and clear overflow and underflow.
REQ-030 SHALL produce zero latency from write to visibility plus one cycle: a word written at edge N appears on dout after edge N when at head.

Reset
REQ-031 SHALL, on rst assertion, clear head, tail, count, overflow, and underflow immediately, regardless of clk.
REQ-032 SHALL hold valid=0, ready=1, almost_full=(AF_TH==0), overflow=0, underflow=0 throughout reset.
REQ-033 SHALL leave storage contents not reset; dout is undefined until first write.
REQ-034 SHALL discard any accepted transfer in flight when rst is asserted mid-operation.

Structure
REQ-035 SHALL place the clog2 width helper and default parameter constants in shared package buffer_pkg.
REQ-036 SHALL use one sub-module, ring_ptr_adv, for the modulo-DEPTH pointer advance by 0..max(PAR_WRITE, PAR_READ), instantiated for head and tail.

Verification
REQ-037 SHALL cover: after reset, write 2 words {5,6} -> next cycle count=2, valid=1, dout lane0=5, lane1=6.
REQ-038 SHALL cover: fill to 59, write_num=2 -> rejected, count stays 59, overflow=1; then write_num=1 -> count=60, ready=0.
REQ-039 SHALL cover: head at 59, read_num=2 -> head=1, dout lane0 = word stored at index 1; no data loss across the wrap.
REQ-040 SHALL cover: count=1, read 2 with write 2 in the same cycle -> read rejected, underflow=1, write accepted, count=3.
REQ-041 SHALL cover: count=10, simultaneous read 2, write 1 -> count=9; then flush -> count=0, overflow=underflow=0.
REQ-042 SHALL cover: rst pulse asserted between clock edges mid-burst -> count=0 and valid=0 immediately, before the next edge.
